// File: rtl/spatz_vfu_if.sv
// Request/response handshake and VRF read/write bus of the Spatz vector functional unit.
// Signal names carry their direction as seen from the functional unit.
interface spatz_vfu_if #(
    parameter int unsigned NrLanes          = 4,
    parameter int unsigned NrWordsPerVector = 8,
    parameter int unsigned IdWidth          = 3,
    parameter int unsigned VlWidth          = 16
);
    localparam int unsigned W  = NrLanes * 32;
    localparam int unsigned B  = NrLanes * 4;
    localparam int unsigned AW = 5 + $clog2(NrWordsPerVector);

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [2:0]               req_op_i;
    logic [1:0]               req_vsew_i;
    logic [VlWidth-1:0]       req_vl_i;
    logic [4:0]               req_vs1_i;
    logic [4:0]               req_vs2_i;
    logic [4:0]               req_vd_i;
    logic                     req_use_vs1_i;
    logic [31:0]              req_rs1_i;
    logic [IdWidth-1:0]       req_id_i;
    logic                     rsp_valid_o;
    logic [IdWidth-1:0]       rsp_id_o;
    logic [1:0][AW-1:0]       vrf_raddr_o;
    logic [1:0]               vrf_re_o;
    logic [1:0][W-1:0]        vrf_rdata_i;
    logic [1:0]               vrf_rvalid_i;
    logic [AW-1:0]            vrf_waddr_o;
    logic [W-1:0]             vrf_wdata_o;
    logic [B-1:0]             vrf_wbe_o;
    logic                     vrf_we_o;
    logic                     vrf_wvalid_i;

    modport slave (
        input  req_valid_i, req_op_i, req_vsew_i, req_vl_i, req_vs1_i, req_vs2_i, req_vd_i,
               req_use_vs1_i, req_rs1_i, req_id_i, vrf_rdata_i, vrf_rvalid_i, vrf_wvalid_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, vrf_raddr_o, vrf_re_o,
               vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_we_o
    );

    modport master (
        output req_valid_i, req_op_i, req_vsew_i, req_vl_i, req_vs1_i, req_vs2_i, req_vd_i,
               req_use_vs1_i, req_rs1_i, req_id_i, vrf_rdata_i, vrf_rvalid_i, vrf_wvalid_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, vrf_raddr_o, vrf_re_o,
               vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_we_o
    );
endinterface

// File: rtl/spatz_vfu_pipe.sv
// Single-issue vector functional unit: streams VRF words through a SIMD integer ALU and a
// Latency-deep pipeline, writing results back with a global write-back stall.
module spatz_vfu_pipe #(
    parameter int unsigned NrLanes          = 4,
    parameter int unsigned Latency          = 2,
    parameter int unsigned NrWordsPerVector = 8,
    parameter int unsigned IdWidth          = 3,
    parameter int unsigned VlWidth          = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    spatz_vfu_if.slave bus
);
    localparam int unsigned W    = NrLanes * 32;
    localparam int unsigned B    = NrLanes * 4;
    localparam int unsigned LogW = $clog2(NrWordsPerVector);
    localparam int unsigned AW   = 5 + LogW;
    localparam int unsigned BW   = $clog2(B + 1);
    localparam int unsigned CW   = VlWidth + 8;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [1:0]         sew_q, sew_d;
    logic [4:0]         vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
    logic               use_vs1_q, use_vs1_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [IdWidth-1:0] id_q, id_d, rsp_id_q, rsp_id_d;
    logic [VlWidth-1:0] nwords_q, nwords_d, icnt_q, icnt_d, wcnt_q, wcnt_d;
    logic [BW-1:0]      lbytes_q, lbytes_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [Latency-1:0] pv_q, pv_d;
    logic [W-1:0]       pd_q [Latency];
    logic [W-1:0]       pd_d [Latency];
    logic [VlWidth-1:0] pi_q [Latency];
    logic [VlWidth-1:0] pi_d [Latency];

    logic [1:0]         req_sew_s;
    logic [CW-1:0]      vlx_s, nwords_s, lastel_s;
    logic [BW-1:0]      lbytes_s;
    logic [W-1:0]       scal_s, opb_s, res_s;
    logic [31:0]        elem_s;
    logic               stall_s, accept_s, wr_acc_s;

    function automatic logic [31:0] elem_op(input logic [2:0] op, input logic [1:0] sew,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ax, bx;
        case (sew)
            2'd0:    begin ax = {{24{a[7]}}, a[7:0]};   bx = {{24{b[7]}}, b[7:0]};   end
            2'd1:    begin ax = {{16{a[15]}}, a[15:0]}; bx = {{16{b[15]}}, b[15:0]}; end
            default: begin ax = a;                      bx = b;                      end
        endcase
        case (op)
            3'd1:    elem_op = a - b;
            3'd2:    elem_op = a & b;
            3'd3:    elem_op = a | b;
            3'd4:    elem_op = a ^ b;
            3'd5:    elem_op = ($signed(ax) < $signed(bx)) ? a : b;
            3'd6:    elem_op = ($signed(ax) > $signed(bx)) ? a : b;
            default: elem_op = a + b;
        endcase
    endfunction

    assign stall_s  = pv_q[Latency-1] & ~bus.vrf_wvalid_i;
    assign accept_s = (state_q == RUN) & bus.vrf_rvalid_i[0]
                    & (~use_vs1_q | bus.vrf_rvalid_i[1]) & ~stall_s;
    assign wr_acc_s = pv_q[Latency-1] & bus.vrf_wvalid_i;

    // Word count and final-word byte count; divisors are constants per element width
    always_comb begin
        req_sew_s = (bus.req_vsew_i == 2'd3) ? 2'd2 : bus.req_vsew_i;
        vlx_s     = CW'(bus.req_vl_i);
        case (req_sew_s)
            2'd0: begin
                nwords_s = (vlx_s + CW'(B - 1)) / CW'(B);
                lastel_s = vlx_s - (nwords_s - CW'(1)) * CW'(B);
            end
            2'd1: begin
                nwords_s = (vlx_s + CW'(B / 2 - 1)) / CW'(B / 2);
                lastel_s = vlx_s - (nwords_s - CW'(1)) * CW'(B / 2);
            end
            default: begin
                nwords_s = (vlx_s + CW'(NrLanes - 1)) / CW'(NrLanes);
                lastel_s = vlx_s - (nwords_s - CW'(1)) * CW'(NrLanes);
            end
        endcase
        lbytes_s = BW'(lastel_s << req_sew_s);
    end

    // Scalar replication and per-element SIMD ALU
    always_comb begin
        res_s  = '0;
        elem_s = '0;
        case (sew_q)
            2'd0:    scal_s = {B{rs1_q[7:0]}};
            2'd1:    scal_s = {(B / 2){rs1_q[15:0]}};
            default: scal_s = {NrLanes{rs1_q}};
        endcase
        opb_s = use_vs1_q ? bus.vrf_rdata_i[1] : scal_s;
        case (sew_q)
            2'd0: begin
                for (int i = 0; i < B; i++) begin
                    elem_s = elem_op(op_q, 2'd0, {24'd0, bus.vrf_rdata_i[0][i*8 +: 8]},
                                     {24'd0, opb_s[i*8 +: 8]});
                    res_s[i*8 +: 8] = elem_s[7:0];
                end
            end
            2'd1: begin
                for (int i = 0; i < B / 2; i++) begin
                    elem_s = elem_op(op_q, 2'd1, {16'd0, bus.vrf_rdata_i[0][i*16 +: 16]},
                                     {16'd0, opb_s[i*16 +: 16]});
                    res_s[i*16 +: 16] = elem_s[15:0];
                end
            end
            default: begin
                for (int i = 0; i < NrLanes; i++) begin
                    elem_s = elem_op(op_q, 2'd2, bus.vrf_rdata_i[0][i*32 +: 32], opb_s[i*32 +: 32]);
                    res_s[i*32 +: 32] = elem_s;
                end
            end
        endcase
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && (bus.req_vl_i != '0)) state_d = RUN;
                else                                         state_d = IDLE;
            end
            RUN: begin
                if (accept_s && ((icnt_q + VlWidth'(1)) == nwords_q)) state_d = DRAIN;
                else                                                  state_d = RUN;
            end
            DRAIN: begin
                if (wr_acc_s && ((wcnt_q + VlWidth'(1)) == nwords_q)) state_d = IDLE;
                else                                                  state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, issue/write counters and completion pulse
    always_comb begin
        op_d = op_q; sew_d = sew_q; vs1_d = vs1_q; vs2_d = vs2_q; vd_d = vd_q;
        use_vs1_d = use_vs1_q; rs1_d = rs1_q; id_d = id_q;
        nwords_d = nwords_q; lbytes_d = lbytes_q; icnt_d = icnt_q; wcnt_d = wcnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        if ((state_q == IDLE) && bus.req_valid_i) begin
            op_d = bus.req_op_i; sew_d = req_sew_s; use_vs1_d = bus.req_use_vs1_i;
            vs1_d = bus.req_vs1_i; vs2_d = bus.req_vs2_i; vd_d = bus.req_vd_i;
            rs1_d = bus.req_rs1_i; id_d = bus.req_id_i;
            nwords_d = VlWidth'(nwords_s); lbytes_d = lbytes_s;
            icnt_d = '0; wcnt_d = '0;
            if (bus.req_vl_i == '0) begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = bus.req_id_i;
            end else begin
                rsp_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) icnt_d = icnt_q + VlWidth'(1);
            else          icnt_d = icnt_q;
            if (wr_acc_s) begin
                wcnt_d = wcnt_q + VlWidth'(1);
                if ((wcnt_q + VlWidth'(1)) == nwords_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end else begin
                wcnt_d = wcnt_q;
            end
        end
    end

    // Pipeline advance; every stage holds while the write-back stage is blocked
    always_comb begin
        pv_d = pv_q;
        for (int k = 0; k < Latency; k++) begin
            pd_d[k] = pd_q[k];
            pi_d[k] = pi_q[k];
        end
        if (!stall_s) begin
            pv_d[0] = accept_s;
            pd_d[0] = res_s;
            pi_d[0] = icnt_q;
            for (int k = 1; k < Latency; k++) begin
                pv_d[k] = pv_q[k-1];
                pd_d[k] = pd_q[k-1];
                pi_d[k] = pi_q[k-1];
            end
        end else begin
            pv_d = pv_q;
        end
    end

    // FSM outputs and VRF port drive
    always_comb begin
        bus.req_ready_o    = (state_q == IDLE);
        bus.vrf_re_o[0]    = (state_q == RUN);
        bus.vrf_re_o[1]    = (state_q == RUN) & use_vs1_q;
        bus.vrf_raddr_o[0] = bus.vrf_re_o[0] ? ((AW'(vs2_q) << LogW) + AW'(icnt_q)) : '0;
        bus.vrf_raddr_o[1] = bus.vrf_re_o[1] ? ((AW'(vs1_q) << LogW) + AW'(icnt_q)) : '0;
        bus.vrf_we_o       = pv_q[Latency-1];
        bus.vrf_wdata_o    = pd_q[Latency-1];
        bus.vrf_waddr_o    = pv_q[Latency-1] ? ((AW'(vd_q) << LogW) + AW'(pi_q[Latency-1])) : '0;
        bus.vrf_wbe_o      = '0;
        for (int b = 0; b < B; b++) begin
            if (!pv_q[Latency-1])                                 bus.vrf_wbe_o[b] = 1'b0;
            else if (pi_q[Latency-1] == (nwords_q - VlWidth'(1))) bus.vrf_wbe_o[b] = (BW'(b) < lbytes_q);
            else                                                  bus.vrf_wbe_o[b] = 1'b1;
        end
        bus.rsp_valid_o    = rsp_valid_q;
        bus.rsp_id_o       = rsp_id_q;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Instruction context, counters, response and pipeline registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q <= 3'd0; sew_q <= 2'd0; vs1_q <= 5'd0; vs2_q <= 5'd0; vd_q <= 5'd0;
            use_vs1_q <= 1'b0; rs1_q <= 32'd0; id_q <= '0; rsp_id_q <= '0;
            nwords_q <= '0; lbytes_q <= '0; icnt_q <= '0; wcnt_q <= '0;
            rsp_valid_q <= 1'b0; pv_q <= '0;
            for (int k = 0; k < Latency; k++) begin
                pd_q[k] <= '0;
                pi_q[k] <= '0;
            end
        end else begin
            op_q <= op_d; sew_q <= sew_d; vs1_q <= vs1_d; vs2_q <= vs2_d; vd_q <= vd_d;
            use_vs1_q <= use_vs1_d; rs1_q <= rs1_d; id_q <= id_d; rsp_id_q <= rsp_id_d;
            nwords_q <= nwords_d; lbytes_q <= lbytes_d; icnt_q <= icnt_d; wcnt_q <= wcnt_d;
            rsp_valid_q <= rsp_valid_d; pv_q <= pv_d;
            for (int k = 0; k < Latency; k++) begin
                pd_q[k] <= pd_d[k];
                pi_q[k] <= pi_d[k];
            end
        end
    end
endmodule

// File: tb/tb_spatz_vfu_pipe.sv
// Scoreboard bench for spatz_vfu_pipe: a behavioural element-level model predicts every
// VRF write and completion id; an independent monitor checks what the DUT presents.
module tb_spatz_vfu_pipe;
    localparam int unsigned NrLanes = 4, Latency = 2, NWPV = 8, IdWidth = 3, VlWidth = 16;
    localparam int unsigned W = NrLanes * 32, B = NrLanes * 4, AW = 5 + $clog2(NWPV);

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [B-1:0]  wbe;
        bit            last;
    } wr_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    spatz_vfu_if #(.NrLanes(NrLanes), .NrWordsPerVector(NWPV), .IdWidth(IdWidth), .VlWidth(VlWidth)) bus ();

    spatz_vfu_pipe #(.NrLanes(NrLanes), .Latency(Latency), .NrWordsPerVector(NWPV),
                     .IdWidth(IdWidth), .VlWidth(VlWidth)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    logic [W-1:0]       mem [256];
    logic [1:0]         rv_bits = 2'b11;
    logic               wv_bit = 1'b1;
    logic               wv_force_low = 1'b0;
    bit                 rv_rand = 1'b0, wv_rand = 1'b0;
    wr_t                exp_w[$];
    logic [IdWidth-1:0] exp_r[$];
    logic [IdWidth-1:0] next_id = '0;
    int                 tests = 0, fails = 0, writes_seen = 0;

    assign bus.vrf_rdata_i  = {mem[bus.vrf_raddr_o[1]], mem[bus.vrf_raddr_o[0]]};
    assign bus.vrf_rvalid_i = rv_bits;
    assign bus.vrf_wvalid_i = wv_bit & ~wv_force_low;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Element-level reference: vd[i] = vs2[i] op (vs1[i] or rs1), at SEW, signed MIN/MAX
    function automatic logic [W-1:0] model_word(input int op, input int sew, input logic [W-1:0] a_w,
                                                input logic [W-1:0] b_w, input bit use_v, input logic [31:0] rs1);
        int esz;
        longint m, half, a, b, r, sa, sb;
        logic [W-1:0] res;
        esz  = 8 << sew;
        m    = (longint'(1) << esz) - 1;
        half = longint'(1) << (esz - 1);
        res  = '0;
        for (int e = 0; e < W / esz; e++) begin
            a  = longint'(a_w >> (e * esz)) & m;
            b  = use_v ? (longint'(b_w >> (e * esz)) & m) : (longint'(rs1) & m);
            sa = (a >= half) ? a - (m + 1) : a;
            sb = (b >= half) ? b - (m + 1) : b;
            case (op)
                1:       r = a - b;
                2:       r = a & b;
                3:       r = a | b;
                4:       r = a ^ b;
                5:       r = (sa < sb) ? a : b;
                6:       r = (sa > sb) ? a : b;
                default: r = a + b;
            endcase
            res = res | (W'(r & m) << (e * esz));
        end
        return res;
    endfunction

    // Called just after a rising edge; returns just after the edge following the handshake
    task automatic issue(input int op, input int sew, input int vl, input int vs1, input int vs2,
                         input int vd, input bit use_v, input logic [31:0] rs1);
        int  sew_e, esz, epw, n, t;
        wr_t e;
        t = 0;
        while (!bus.req_ready_o && t < 1000) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (!bus.req_ready_o) chk("req_ready_timeout", W'(bus.req_ready_o), W'(1));
        sew_e = (sew == 3) ? 2 : sew;
        esz   = 8 << sew_e;
        epw   = B >> sew_e;
        n     = (vl + epw - 1) / epw;
        for (int w = 0; w < n; w++) begin
            e.addr = AW'(vd * NWPV + w);
            e.data = model_word(op, sew_e, mem[(vs2 * NWPV + w) % 256], mem[(vs1 * NWPV + w) % 256], use_v, rs1);
            for (int b = 0; b < B; b++) e.wbe[b] = ((w * epw + b / (esz / 8)) < vl);
            e.last = (w == n - 1);
            exp_w.push_back(e);
        end
        exp_r.push_back(next_id);
        bus.req_op_i = 3'(op); bus.req_vsew_i = 2'(sew); bus.req_vl_i = VlWidth'(vl);
        bus.req_vs1_i = 5'(vs1); bus.req_vs2_i = 5'(vs2); bus.req_vd_i = 5'(vd);
        bus.req_use_vs1_i = use_v; bus.req_rs1_i = rs1; bus.req_id_i = next_id;
        bus.req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        next_id = next_id + IdWidth'(1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_w.size() != 0 || exp_r.size() != 0) && t < 2000) begin
            @(posedge clk_i); #1;
            t++;
        end
        chk("drain_writes_left", W'(exp_w.size()), W'(0));
        chk("drain_rsps_left", W'(exp_r.size()), W'(0));
    endtask

    // Random read/write acceptance, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk_i); #1;
            rv_bits = rv_rand ? {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)} : 2'b11;
            wv_bit  = wv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compares every accepted write and every completion against the scoreboard
    initial begin
        bit  last_prev, stall_prev;
        wr_t e;
        logic [W-1:0] bm;
        last_prev  = 1'b0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                last_prev  = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) chk("stall_hold_we", W'(bus.vrf_we_o), W'(1));
                if (last_prev)  chk("rsp_after_last_write", W'(bus.rsp_valid_o), W'(1));
                last_prev  = 1'b0;
                stall_prev = bus.vrf_we_o && !bus.vrf_wvalid_i;
                if (bus.vrf_we_o && bus.vrf_wvalid_i) begin
                    if (exp_w.size() == 0) begin
                        chk("unexpected_write", W'(bus.vrf_we_o), W'(0));
                    end else begin
                        e = exp_w.pop_front();
                        for (int b = 0; b < B; b++) bm[b*8 +: 8] = {8{e.wbe[b]}};
                        chk("waddr", W'(bus.vrf_waddr_o), W'(e.addr));
                        chk("wbe", W'(bus.vrf_wbe_o), W'(e.wbe));
                        chk("wdata", bus.vrf_wdata_o & bm, e.data & bm);
                        writes_seen++;
                        last_prev = e.last;
                    end
                end
                if (bus.rsp_valid_o) begin
                    if (exp_r.size() == 0) chk("unexpected_rsp", W'(bus.rsp_valid_o), W'(0));
                    else                   chk("rsp_id", W'(bus.rsp_id_o), W'(exp_r.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t, op, sew, epw, vl;
        bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_vsew_i = '0; bus.req_vl_i = '0;
        bus.req_vs1_i = '0; bus.req_vs2_i = '0; bus.req_vd_i = '0; bus.req_use_vs1_i = 1'b0;
        bus.req_rs1_i = '0; bus.req_id_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NWPV; i++) begin
            mem[4 * NWPV + i] = '0;
            mem[5 * NWPV + i] = {(W / 16){16'h8000}};
            mem[6 * NWPV + i] = {(W / 16){16'h7FFF}};
        end

        #12;
        chk("reset_req_ready", W'(bus.req_ready_o), W'(1));
        chk("reset_outputs", W'({bus.rsp_valid_o, bus.vrf_re_o, bus.vrf_we_o}), W'(0));
        chk("reset_wbe_waddr", W'({bus.vrf_wbe_o, bus.vrf_waddr_o}), W'(0));
        @(negedge clk_i); #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        issue(0, 2, 10, 2, 1, 3, 1'b1, 32'd0);
        wait_drain();
        issue(1, 0, 16, 0, 4, 7, 1'b0, 32'h01);
        wait_drain();
        issue(5, 1, 8, 6, 5, 8, 1'b1, 32'd0);
        issue(6, 1, 8, 6, 5, 9, 1'b1, 32'd0);
        wait_drain();

        // Write-back blocked for five cycles during a four-word run
        issue(0, 2, 16, 10, 11, 12, 1'b1, 32'd0);
        t = 0;
        while (!bus.vrf_we_o && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        chk("stall_first_write_seen", W'(bus.vrf_we_o), W'(1));
        wv_force_low = 1'b1;
        repeat (5) @(posedge clk_i);
        #1 wv_force_low = 1'b0;
        wait_drain();

        // Zero-length instruction
        issue(2, 0, 0, 1, 2, 3, 1'b1, 32'd0);
        chk("vl0_rsp_pulse", W'(bus.rsp_valid_o), W'(1));
        for (int i = 0; i < 4; i++) begin
            chk("vl0_no_vrf_access", W'({bus.vrf_re_o, bus.vrf_we_o}), W'(0));
            @(posedge clk_i); #1;
        end
        wait_drain();

        // Reset after the second of four writes, then a fresh instruction
        issue(4, 2, 16, 13, 14, 15, 1'b1, 32'd0);
        base = writes_seen;
        t = 0;
        while (writes_seen < base + 2 && t < 200) begin
            @(negedge clk_i); #2;
            t++;
        end
        chk("rst_two_writes_seen", W'(writes_seen - base), W'(2));
        rst_ni = 1'b0;
        exp_w.delete();
        exp_r.delete();
        #1;
        chk("midrst_req_ready", W'(bus.req_ready_o), W'(1));
        chk("midrst_outputs", W'({bus.rsp_valid_o, bus.vrf_re_o, bus.vrf_we_o}), W'(0));
        chk("midrst_wbe_addr", W'({bus.vrf_wbe_o, bus.vrf_waddr_o, bus.vrf_raddr_o}), W'(0));
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_quiet", W'({bus.rsp_valid_o, bus.vrf_re_o, bus.vrf_we_o}), W'(0));
            @(posedge clk_i); #1;
        end
        issue(0, 2, 4, 16, 17, 18, 1'b0, 32'h1234_5678);
        wait_drain();

        // Randomised back-to-back traffic with random VRF acceptance
        rv_rand = 1'b1;
        wv_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 7);
            sew = $urandom_range(0, 3);
            epw = B >> ((sew == 3) ? 2 : sew);
            vl  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, NWPV * epw);
            issue(op, sew, vl, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  1'($urandom_range(0, 1)), $urandom);
        end
        wait_drain();
        repeat (4) @(posedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
